// File: rtl/bcd_window_scroller.sv
// rtl/bcd_window_scroller.sv - captures a BCD product and presents a saturating 3-digit scroll window
module bcd_window_scroller #(
    parameter int DIGITS   = 5,
    parameter int WIN      = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_posedge,
    input  logic                  done,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  negative,
    input  logic                  sh_left,
    input  logic                  sh_right,
    output logic [3:0]            dig0,
    output logic [3:0]            dig1,
    output logic [3:0]            dig2,
    output logic [2:0]            dig_blank,
    output logic                  show_sign,
    output logic                  more_left,
    output logic                  more_right,
    output logic [1:0]            pos,
    output logic                  valid
);

    localparam int         IW      = $clog2(DIGITS) + 2;
    localparam logic [1:0] POS_MAX = 2'(DIGITS - WIN);

    logic [4*DIGITS-1:0] held_q;
    logic                neg_q;
    logic [IW-1:0]       msd_q, msd_d;
    logic [1:0]          pos_q, pos_d;
    logic                valid_q;
    logic                done_q;
    logic                armed_q;
    logic                capture;

    // armed_q blocks a capture when done is already high as reset releases
    assign capture = done & ~done_q & armed_q;

    always_comb begin
        msd_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd_d = IW'(i);
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (capture) begin
            pos_d = 2'd0;
        end else if (valid_q) begin
            if (sh_left && !sh_right && pos_q < POS_MAX)
                pos_d = pos_q + 2'd1;
            else if (sh_right && !sh_left && pos_q != 2'd0)
                pos_d = pos_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_posedge) begin
        if (rst_posedge) begin
            held_q  <= '0;
            neg_q   <= 1'b0;
            msd_q   <= '0;
            pos_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            done_q <= done;
            pos_q  <= pos_d;
            if (!done) armed_q <= 1'b1;
            if (capture) begin
                held_q  <= bcd;
                neg_q   <= negative;
                msd_q   <= msd_d;
                valid_q <= 1'b1;
            end
        end
    end

    logic [3:0]          win_dig [3];
    logic [2:0]          win_blank;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shifted;

    always_comb begin
        idx       = '0;
        shifted   = '0;
        win_blank = 3'b111;
        for (int k = 0; k < 3; k++) begin
            idx        = IW'(pos_q) + IW'(k);
            shifted    = held_q >> {idx, 2'b00};
            win_dig[k] = shifted[3:0];
            if (valid_q)
                win_blank[k] = (BLANK_LZ != 0) && (idx > msd_q) && (idx != '0);
        end
    end

    assign dig0       = win_dig[0];
    assign dig1       = win_dig[1];
    assign dig2       = win_dig[2];
    assign dig_blank  = win_blank;
    assign show_sign  = valid_q & neg_q & (|held_q);
    assign more_left  = valid_q & ((IW'(pos_q) + IW'(WIN - 1)) < msd_q);
    assign more_right = valid_q & (pos_q != 2'd0);
    assign pos        = pos_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_bcd_window_scroller.sv
// tb/tb_bcd_window_scroller.sv - directed and random checks of bcd_window_scroller against a digit-array model
module tb_bcd_window_scroller;

    localparam int DIGITS = 5;
    localparam int WIN    = 3;
    localparam int MAXP   = DIGITS - WIN;

    logic        clk = 1'b0;
    logic        rst_posedge = 1'b1;
    logic        done = 1'b0;
    logic [19:0] bcd = '0;
    logic        negative = 1'b0;
    logic        sh_left = 1'b0;
    logic        sh_right = 1'b0;
    logic [3:0]  dig0, dig1, dig2;
    logic [2:0]  dig_blank;
    logic        show_sign, more_left, more_right, valid;
    logic [1:0]  pos;

    bcd_window_scroller #(.DIGITS(DIGITS), .WIN(WIN), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_posedge(rst_posedge), .done(done), .bcd(bcd),
        .negative(negative), .sh_left(sh_left), .sh_right(sh_right),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig_blank(dig_blank),
        .show_sign(show_sign), .more_left(more_left), .more_right(more_right),
        .pos(pos), .valid(valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_dig [DIGITS];
    bit m_neg, m_valid, m_prev, m_have_prev;
    int m_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_msd();
        int m = 0;
        for (int i = 0; i < DIGITS; i++) if (m_dig[i] != 0) m = i;
        return m;
    endfunction

    function automatic bit m_nonzero();
        for (int i = 0; i < DIGITS; i++) if (m_dig[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        m_neg = 0; m_valid = 0; m_pos = 0; m_prev = 0; m_have_prev = 0;
    endtask

    task automatic model_edge(input bit d, input logic [19:0] b, input bit n, input bit l, input bit r);
        if (d && m_have_prev && !m_prev) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = int'(b[4*i +: 4]);
            m_neg = n; m_valid = 1; m_pos = 0;
        end else if (m_valid) begin
            if (l && !r) m_pos = (m_pos + 1 > MAXP) ? MAXP : m_pos + 1;
            else if (r && !l) m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
        end
        m_prev = d;
        m_have_prev = 1;
    endtask

    task automatic check_all(input string tag);
        logic [2:0] eb;
        int msd = m_msd();
        for (int k = 0; k < 3; k++)
            eb[k] = m_valid ? ((m_pos + k > msd) && (m_pos + k != 0)) : 1'b1;
        chk({tag, ".valid"}, valid, m_valid);
        chk({tag, ".pos"}, pos, m_pos);
        chk({tag, ".dig0"}, dig0, m_dig[m_pos]);
        chk({tag, ".dig1"}, dig1, m_dig[m_pos + 1]);
        chk({tag, ".dig2"}, dig2, m_dig[m_pos + 2]);
        chk({tag, ".blank"}, dig_blank, eb);
        chk({tag, ".sign"}, show_sign, m_valid && m_neg && m_nonzero());
        chk({tag, ".more_left"}, more_left, m_valid && (m_pos + WIN - 1 < msd));
        chk({tag, ".more_right"}, more_right, m_valid && (m_pos != 0));
    endtask

    task automatic step(input string tag, input bit d, input logic [19:0] b, input bit n,
                        input bit l, input bit r);
        done = d; bcd = b; negative = n; sh_left = l; sh_right = r;
        @(posedge clk);
        #1;
        model_edge(d, b, n, l, r);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag, input bit d);
        @(negedge clk);
        #2;
        done = d; sh_left = 0; sh_right = 0;
        rst_posedge = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".blank111"}, dig_blank, 3'b111);
        @(negedge clk);
        rst_posedge = 1'b0;
    endtask

    logic [19:0] rb;

    initial begin
        model_reset();
        #2;
        check_all("reset");
        chk("reset.blank111", dig_blank, 3'b111);
        @(negedge clk);
        rst_posedge = 1'b0;

        step("idle_left0", 0, 20'h12345, 0, 1, 0);
        step("idle_left1", 0, 20'h12345, 0, 1, 0);
        chk("idle.pos0", pos, 0);

        step("cap16256", 1, 20'h16256, 0, 0, 0);
        chk("cap16256.d2", dig2, 2);
        chk("cap16256.d1", dig1, 5);
        chk("cap16256.d0", dig0, 6);
        chk("cap16256.ml", more_left, 1);
        chk("cap16256.bl", dig_blank, 3'b000);
        step("l1", 1, 20'h0, 0, 1, 0);
        chk("l1.pos", pos, 1);
        step("l2", 1, 20'h0, 0, 1, 0);
        chk("l2.pos", pos, 2);
        step("l3sat", 1, 20'h0, 0, 1, 0);
        chk("l3sat.pos", pos, 2);
        chk("l3sat.win", {dig2, dig1, dig0}, 12'h162);
        chk("l3sat.mr", more_right, 1);
        for (int i = 0; i < 3; i++) step("r", 0, 20'h0, 0, 0, 1);
        chk("r3.pos", pos, 0);

        step("pre35", 0, 20'h00035, 1, 0, 0);
        step("cap35", 1, 20'h00035, 1, 0, 0);
        chk("cap35.bl", dig_blank, 3'b100);
        chk("cap35.sign", show_sign, 1);
        step("cap35.l", 1, 20'h0, 0, 1, 0);
        chk("cap35.l.bl", dig_blank, 3'b110);
        chk("cap35.l.d0", dig0, 3);

        step("pre0", 0, 20'h0, 1, 0, 0);
        step("cap0", 1, 20'h0, 1, 0, 0);
        chk("cap0.sign", show_sign, 0);
        chk("cap0.bl", dig_blank, 3'b110);
        step("cap0.l", 1, 20'h0, 0, 1, 0);
        step("both", 1, 20'h0, 0, 1, 1);
        chk("both.pos", pos, 1);

        step("precl", 0, 20'h98765, 0, 1, 0);
        step("capl", 1, 20'h98765, 0, 1, 0);
        chk("capl.pos", pos, 0);

        step("ms.l", 1, 20'h0, 0, 1, 0);
        async_reset("midrst", 0);

        async_reset("rst_done_hi", 1);
        step("hi0", 1, 20'h11111, 0, 0, 0);
        step("hi1", 1, 20'h11111, 0, 0, 0);
        chk("hi1.valid", valid, 0);
        step("hi.lo", 0, 20'h11111, 0, 0, 0);
        step("hi.cap", 1, 20'h11111, 0, 0, 0);
        chk("hi.cap.valid", valid, 1);

        for (int n = 0; n < 400; n++) begin
            int nd;
            rb = '0;
            nd = $urandom_range(0, DIGITS);
            for (int i = 0; i < nd; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 99) < 2) async_reset("rnd_rst", 1'($urandom_range(0, 1)));
            step("rnd", ($urandom_range(0, 3) == 0) ? ~done : done, rb,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_window_scroller.md
Name: bcd_window_scroller

Overview:
Downstream of the sequential multiplier and binary-to-BCD converter; upstream of the 3-digit-plus-sign display driver. Captures the BCD product on the rising edge of the multiplier's done level, holds it, and presents a 3-digit window that the shift buttons scroll. The window saturates at both ends rather than shifting digits out. Adds leading-zero blanking, sign gating and more-digits indicators.

Parameters:
DIGITS, 5, number of BCD digits in the captured product; bcd width = 4*DIGITS.
WIN, 3, digits in the visible window; fixed at 3 for the current display.
BLANK_LZ, 1, 1 = blank window digits above the most-significant nonzero digit; 0 = show all zeros.

Ports:
clk  in  1  system clock, all state on posedge.
rst_posedge  in  1  reset, asynchronous, active-high.
done  in  1  multiplier done level; capture on its 0->1 transition.
bcd  in  4*DIGITS  BCD product, digit 0 in bits [3:0]; sampled only at capture.
negative  in  1  product sign (XOR of operand signs); sampled at capture.
sh_left  in  1  one-cycle pulse; move window toward more-significant digits.
sh_right  in  1  one-cycle pulse; move window toward less-significant digits.
dig0, dig1, dig2  out  4 each  window digits, dig0 least significant.
dig_blank  out  3  bit i = 1 blanks digit i.
show_sign  out  1  drive the display minus sign.
more_left  out  1  nonzero digits exist above the window.
more_right  out  1  digits exist below the window (pos > 0).
pos  out  2  window base digit index, 0..DIGITS-WIN.
valid  out  1  a product has been captured since reset.

Behaviour:
- Reset (async, immediate): held value 0, negative 0, msd 0, pos 0, valid 0, done_q 0.
  - Outputs during reset: dig0..2 = 0, dig_blank = 3'b111, show_sign 0, more_left 0, more_right 0.
- Edge detect: done_q registers done each cycle. Capture fires when done & ~done_q.
- Capture, visible on the next cycle:
  - Hold bcd and negative; set valid = 1; pos = 0.
  - msd = index of the highest nonzero digit, or 0 if all digits are zero.
- done high continuously: no recapture. done falling: no effect, held data is kept.
- Scroll, only when valid = 1; pulses are ignored while valid = 0:
  - sh_left alone: pos = min(pos+1, DIGITS-WIN).
  - sh_right alone: pos = max(pos-1, 0).
  - sh_left and sh_right in the same cycle: no change.
  - Saturation: no wrap-around; pulses at a limit are no-ops.
- Capture and a shift pulse in the same cycle: capture wins, pos = 0.
- Window contents: dig_k = held digit (pos+k), for k = 0..2.
- Blanking, only when valid = 1: dig_blank[k] = BLANK_LZ & ((pos+k) > msd) & ((pos+k) != 0).
  - Absolute digit 0 is never blanked.
- show_sign = valid & negative & (held value != 0). A negative-zero product shows no sign.
- Indicators:
  - more_left = valid & ((pos+WIN-1) < msd).
  - more_right = valid & (pos != 0).
- Timing: all outputs are registered or decoded from registers only. Latency from capture edge or shift pulse to outputs is 1 clk.
- Reset mid-operation: state clears immediately. The next done rising edge after reset release captures normally. If done is already high at release, no capture occurs until done drops and rises again.

Test Plan:
- Reset released, done 0, sh_left pulses -> valid 0, dig_blank 111, pos 0, all outputs 0.
- bcd=20'h16256, negative 0, done 0->1 -> next clk: dig2..0 = 2,5,6; dig_blank 000; more_left 1; more_right 0; pos 0.
- Same held value, sh_left x3 -> pos 1 then 2 then 2 (saturated); window 1,6,2; more_left 0; more_right 1. Then sh_right x3 -> pos 0.
- bcd=20'h00035, negative 1, capture -> dig 0,3,5; dig_blank 100; show_sign 1; msd 1. Then sh_left -> pos 1, dig_blank 110, dig0 = 3.
- bcd=20'h00000, negative 1, capture -> show_sign 0; dig_blank 110; dig0 = 0.
- Simultaneous sh_left and sh_right at pos 1 -> pos unchanged.
- Capture coincident with sh_left -> pos 0.
- rst_posedge asserted mid-scroll -> outputs revert to reset values without waiting for a clock edge.
- With done held high through reset release -> no capture until done toggles low then high.
